// File: rtl/serial_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : serial_pkg
//  Description : Shared types and constants for the serial TX arbiter:
//                arbiter state encoding, default requester count, default
//                stall timeout and the system clock rate.
//  Revision    : 1.0  initial release
// ============================================================================
package serial_pkg;

   // Arbiter states: no packet, byte presented to UART, lock held between bytes
   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_SEND      = 2'd1,
      ST_WAIT_NEXT = 2'd2
   } arb_state_t;

   localparam int c_NUM_REQ_DEFAULT      = 4;
   localparam int c_IDLE_TIMEOUT_DEFAULT = 50000;
   localparam int c_CLK_FREQ_HZ          = 48_000_000;

endpackage : serial_pkg
`default_nettype wire

// File: rtl/rr_priority_pick.sv
`default_nettype none
// ============================================================================
//  Module      : rr_priority_pick
//  Description : Round-robin pick. Returns the first asserted request found
//                when searching upward from i_ptr with wrap-around.
//  Ports       : i_req   [N-1:0]  request vector
//                i_ptr   [W-1:0]  search start index (0..N-1)
//                o_grant [N-1:0]  one-hot grant (all zero if no request)
//                o_idx   [W-1:0]  index of the granted request
//                o_any            at least one request is asserted
//  Revision    : 1.0  initial release
// ============================================================================
module rr_priority_pick #(
   parameter int N = 4,
   parameter int W = 2
) (
   input  logic [N-1:0] i_req,
   input  logic [W-1:0] i_ptr,
   output logic [N-1:0] o_grant,
   output logic [W-1:0] o_idx,
   output logic         o_any
);

   int w_j;

   // Walk offsets from farthest to nearest so the nearest request to the
   // pointer is the last one written and therefore wins.
   always_comb begin
      o_grant = '0;
      o_idx   = '0;
      o_any   = 1'b0;
      w_j     = 0;
      for (int k = N - 1; k >= 0; k--) begin
         w_j = int'(i_ptr) + k;
         if (w_j >= N) begin
            w_j = w_j - N;
         end
         if (i_req[w_j]) begin
            o_grant      = '0;
            o_grant[w_j] = 1'b1;
            o_idx        = W'(w_j);
            o_any        = 1'b1;
         end
      end
   end

endmodule : rr_priority_pick
`default_nettype wire

// File: rtl/serial_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : serial_tx_arbiter
//  Description : Round-robin, packet-locking arbiter that funnels bytes from
//                NUM_REQ requesters into a single UART transmitter. A lock is
//                held until the last byte of a packet, or revoked when the
//                owner stalls for IDLE_TIMEOUT cycles between bytes.
//  Ports       : clock, reset_n (async, active-low)
//                req_data/req_valid/req_last/req_ready  per-requester stream
//                tx_data/tx_data_available/tx_ready     UART handshake
//                owner, busy, timeout_pulse              status
//  Revision    : 1.0  initial release
// ============================================================================
module serial_tx_arbiter
   import serial_pkg::*;
#(
   parameter int NUM_REQ      = c_NUM_REQ_DEFAULT,
   parameter int IDLE_TIMEOUT = c_IDLE_TIMEOUT_DEFAULT
) (
   input  logic                       clock,
   input  logic                       reset_n,
   input  logic [NUM_REQ-1:0][7:0]    req_data,
   input  logic [NUM_REQ-1:0]         req_valid,
   input  logic [NUM_REQ-1:0]         req_last,
   output logic [NUM_REQ-1:0]         req_ready,
   output logic [7:0]                 tx_data,
   output logic                       tx_data_available,
   input  logic                       tx_ready,
   output logic [$clog2(NUM_REQ)-1:0] owner,
   output logic                       busy,
   output logic                       timeout_pulse
);

   localparam int IDX_W = $clog2(NUM_REQ);
   localparam int CNT_W = $clog2(IDLE_TIMEOUT + 1);

   arb_state_t          r_state;
   arb_state_t          w_state_nxt;
   logic [IDX_W-1:0]    r_rr_ptr;
   logic [IDX_W-1:0]    r_owner;
   logic [7:0]          r_hold_data;
   logic                r_hold_last;
   logic [CNT_W-1:0]    r_stall_cnt;
   logic                r_timeout_pulse;

   logic [NUM_REQ-1:0]  w_grant;
   logic [IDX_W-1:0]    w_pick_idx;
   logic                w_pick_any;
   logic [NUM_REQ-1:0]  w_req_ready;
   logic                w_accept;
   logic [IDX_W-1:0]    w_src;
   logic                w_rr_adv;
   logic                w_stall_clr;
   logic                w_timeout;
   logic                w_owner_valid;
   logic                w_stall_expired;
   logic [IDX_W-1:0]    w_owner_next;

   rr_priority_pick #(
      .N (NUM_REQ),
      .W (IDX_W)
   ) u_pick (
      .i_req   (req_valid),
      .i_ptr   (r_rr_ptr),
      .o_grant (w_grant),
      .o_idx   (w_pick_idx),
      .o_any   (w_pick_any)
   );

   assign w_owner_valid   = req_valid[r_owner];
   assign w_stall_expired = (r_stall_cnt == CNT_W'(IDLE_TIMEOUT - 1));
   assign w_owner_next    = (r_owner == IDX_W'(NUM_REQ - 1)) ? '0 : r_owner + 1'b1;

   // State register
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state and handshake decode
   always_comb begin
      w_state_nxt = r_state;
      w_req_ready = '0;
      w_accept    = 1'b0;
      w_src       = r_owner;
      w_rr_adv    = 1'b0;
      w_stall_clr = 1'b0;
      w_timeout   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_pick_any) begin
               w_req_ready = w_grant;
               w_accept    = 1'b1;
               w_src       = w_pick_idx;
               w_state_nxt = ST_SEND;
            end
         end
         ST_SEND: begin
            if (tx_ready) begin
               if (r_hold_last) begin
                  w_rr_adv    = 1'b1;
                  w_state_nxt = ST_IDLE;
               end else begin
                  w_stall_clr = 1'b1;
                  w_state_nxt = ST_WAIT_NEXT;
               end
            end
         end
         ST_WAIT_NEXT: begin
            // Only the lock holder is served; an arriving byte beats the timeout
            w_req_ready[r_owner] = 1'b1;
            if (w_owner_valid) begin
               w_accept    = 1'b1;
               w_src       = r_owner;
               w_state_nxt = ST_SEND;
            end else if (w_stall_expired) begin
               w_timeout   = 1'b1;
               w_rr_adv    = 1'b1;
               w_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // Holding register, ownership, pointer and stall counter
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_rr_ptr        <= '0;
         r_owner         <= '0;
         r_hold_data     <= 8'h00;
         r_hold_last     <= 1'b0;
         r_stall_cnt     <= '0;
         r_timeout_pulse <= 1'b0;
      end else begin
         if (w_accept) begin
            r_hold_data <= req_data[w_src];
            r_hold_last <= req_last[w_src];
            r_owner     <= w_src;
         end
         if (w_rr_adv) begin
            r_rr_ptr <= w_owner_next;
         end
         // Counter saturates at IDLE_TIMEOUT so a long stall can never wrap
         if (w_stall_clr) begin
            r_stall_cnt <= '0;
         end else if ((r_state == ST_WAIT_NEXT) && !w_owner_valid &&
                      (r_stall_cnt != CNT_W'(IDLE_TIMEOUT))) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
         end
         r_timeout_pulse <= w_timeout;
      end
   end

   assign req_ready         = w_req_ready;
   assign tx_data           = r_hold_data;
   assign tx_data_available = (r_state == ST_SEND);
   assign busy              = (r_state != ST_IDLE);
   assign owner             = r_owner;
   assign timeout_pulse     = r_timeout_pulse;

endmodule : serial_tx_arbiter
`default_nettype wire

// File: tb/tb_serial_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_tx_arbiter
//  Description : Directed self-checking bench for serial_tx_arbiter
//                (NUM_REQ=4, IDLE_TIMEOUT=16).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_serial_tx_arbiter;

   localparam int NREQ = 4;
   localparam int TMO  = 16;

   logic                  clock = 1'b0;
   logic                  reset_n;
   logic [NREQ-1:0][7:0]  req_data;
   logic [NREQ-1:0]       req_valid;
   logic [NREQ-1:0]       req_last;
   logic [NREQ-1:0]       req_ready;
   logic [7:0]            tx_data;
   logic                  tx_data_available;
   logic                  tx_ready;
   logic [1:0]            owner;
   logic                  busy;
   logic                  timeout_pulse;

   int checks = 0;
   int errors = 0;
   int bad_avail, bad_data, bad_rdy, bad_pulse;

   serial_tx_arbiter #(
      .NUM_REQ      (NREQ),
      .IDLE_TIMEOUT (TMO)
   ) dut (
      .clock             (clock),
      .reset_n           (reset_n),
      .req_data          (req_data),
      .req_valid         (req_valid),
      .req_last          (req_last),
      .req_ready         (req_ready),
      .tx_data           (tx_data),
      .tx_data_available (tx_data_available),
      .tx_ready          (tx_ready),
      .owner             (owner),
      .busy              (busy),
      .timeout_pulse     (timeout_pulse)
   );

   always #5 clock = ~clock;

   task automatic edge_();
      @(posedge clock);
      #1;
   endtask

   task automatic mid();
      @(negedge clock);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n   = 1'b0;
      req_valid = '0;
      req_last  = '0;
      req_data  = '0;
      tx_ready  = 1'b0;

      // ---------------- reset state
      edge_(); edge_(); mid();
      chk("rst_avail", 32'(tx_data_available), 32'd0);
      chk("rst_data",  32'(tx_data), 32'h00);
      chk("rst_busy",  32'(busy), 32'd0);
      chk("rst_pulse", 32'(timeout_pulse), 32'd0);
      chk("rst_ready", 32'(req_ready), 32'h0);
      reset_n = 1'b1;
      edge_();

      // ---------------- round-robin of two single-byte packets
      tx_ready    = 1'b1;
      req_data[0] = 8'h41; req_last[0] = 1'b1;
      req_data[2] = 8'h42; req_last[2] = 1'b1;
      req_valid   = 4'b0101;
      mid();  chk("t1_grant0", 32'(req_ready), 32'b0001);
      edge_(); req_valid[0] = 1'b0;
      mid();  chk("t1_avail0", 32'(tx_data_available), 32'd1);
              chk("t1_data0",  32'(tx_data), 32'h41);
              chk("t1_owner0", 32'(owner), 32'd0);
              chk("t1_send_rdy", 32'(req_ready), 32'h0);
      edge_(); mid();
              chk("t1_grant2", 32'(req_ready), 32'b0100);
              chk("t1_idle_busy", 32'(busy), 32'd0);
      edge_(); req_valid[2] = 1'b0;
      mid();  chk("t1_data2",  32'(tx_data), 32'h42);
              chk("t1_owner2", 32'(owner), 32'd2);
      edge_(); mid();
              chk("t1_end_avail", 32'(tx_data_available), 32'd0);
      req_valid = 4'b1001; #1;
              chk("t1_ptr3", 32'(req_ready), 32'b1000);
      req_valid = '0; req_last = '0;

      // ---------------- packet lock: req1 "HI\n" while req0 waits
      edge_();
      req_data[1] = 8'h48; req_last[1] = 1'b0; req_valid = 4'b0010;
      mid();  chk("t2_grant1", 32'(req_ready), 32'b0010);
      edge_();
      req_data[1] = 8'h49; req_data[0] = 8'h55; req_last[0] = 1'b1; req_valid = 4'b0011;
      mid();  chk("t2_byte_H", 32'(tx_data), 32'h48);
              chk("t2_send_rdy", 32'(req_ready), 32'h0);
      edge_(); mid();
              chk("t2_lock_rdy", 32'(req_ready), 32'b0010);
              chk("t2_lock_busy", 32'(busy), 32'd1);
              chk("t2_wait_avail", 32'(tx_data_available), 32'd0);
      edge_(); req_data[1] = 8'h0A; req_last[1] = 1'b1;
      mid();  chk("t2_byte_I", 32'(tx_data), 32'h49);
      edge_(); mid();
              chk("t2_lock_rdy2", 32'(req_ready), 32'b0010);
      edge_(); req_valid[1] = 1'b0;
      mid();  chk("t2_byte_nl", 32'(tx_data), 32'h0A);
      edge_(); mid();
              chk("t2_grant0", 32'(req_ready), 32'b0001);
      edge_(); req_valid[0] = 1'b0;
      mid();  chk("t2_byte_r0", 32'(tx_data), 32'h55);
              chk("t2_owner0", 32'(owner), 32'd0);
      edge_();

      // ---------------- backpressure for 5000 cycles
      tx_ready    = 1'b0;
      req_data[2] = 8'h77; req_last[2] = 1'b1; req_valid = 4'b0100;
      mid();  chk("t3_grant2", 32'(req_ready), 32'b0100);
      edge_(); req_valid = 4'b0011;
      bad_avail = 0; bad_data = 0; bad_rdy = 0;
      for (int i = 0; i < 5000; i++) begin
         mid();
         if (tx_data_available !== 1'b1) bad_avail++;
         if (tx_data !== 8'h77)           bad_data++;
         if (req_ready !== 4'b0000)       bad_rdy++;
         edge_();
      end
      chk("t3_hold_avail", 32'(bad_avail), 32'd0);
      chk("t3_hold_data",  32'(bad_data), 32'd0);
      chk("t3_hold_rdy",   32'(bad_rdy), 32'd0);
      tx_ready = 1'b1;
      mid();  chk("t3_avail_before", 32'(tx_data_available), 32'd1);
      edge_(); mid();
              chk("t3_next_grant", 32'(req_ready), 32'b0001);
              chk("t3_idle_busy", 32'(busy), 32'd0);
      req_valid = '0;

      // ---------------- timeout: req3 stalls mid-packet
      edge_();
      req_data[3] = 8'h33; req_last[3] = 1'b0; req_valid = 4'b1000;
      mid();  chk("t4_grant3", 32'(req_ready), 32'b1000);
      edge_(); req_valid = '0;
      mid();  chk("t4_data", 32'(tx_data), 32'h33);
              chk("t4_owner3", 32'(owner), 32'd3);
      edge_();  // now in WAIT_NEXT
      req_data[0] = 8'h99; req_last[0] = 1'b1; req_valid = 4'b0001;
      bad_pulse = 0; bad_rdy = 0;
      for (int k = 0; k < TMO; k++) begin
         mid();
         if (timeout_pulse !== 1'b0 || busy !== 1'b1) bad_pulse++;
         if (req_ready !== 4'b1000) bad_rdy++;
         edge_();
      end
      chk("t4_no_early_pulse", 32'(bad_pulse), 32'd0);
      chk("t4_wait_rdy", 32'(bad_rdy), 32'd0);
      mid();  chk("t4_pulse", 32'(timeout_pulse), 32'd1);
              chk("t4_busy_drop", 32'(busy), 32'd0);
              chk("t4_next_grant", 32'(req_ready), 32'b0001);
      edge_(); req_valid = '0;
      mid();  chk("t4_pulse_one", 32'(timeout_pulse), 32'd0);
              chk("t4_data0", 32'(tx_data), 32'h99);
              chk("t4_owner0", 32'(owner), 32'd0);
      edge_();

      // ---------------- timeout collision
      req_data[1] = 8'h11; req_last[1] = 1'b0; req_valid = 4'b0010;
      mid();  chk("t5_grant1", 32'(req_ready), 32'b0010);
      edge_(); req_valid = '0;
      edge_();  // now in WAIT_NEXT, stall 0
      for (int k = 0; k < TMO - 1; k++) begin
         edge_();
      end
      req_data[1] = 8'h12; req_last[1] = 1'b1; req_valid = 4'b0010;
      mid();  chk("t5_rdy", 32'(req_ready), 32'b0010);
              chk("t5_busy", 32'(busy), 32'd1);
      edge_(); req_valid = '0;
      mid();  chk("t5_no_pulse", 32'(timeout_pulse), 32'd0);
              chk("t5_busy_kept", 32'(busy), 32'd1);
              chk("t5_avail", 32'(tx_data_available), 32'd1);
              chk("t5_data", 32'(tx_data), 32'h12);
      edge_(); mid();
              chk("t5_no_pulse2", 32'(timeout_pulse), 32'd0);
              chk("t5_idle", 32'(busy), 32'd0);

      // ---------------- asynchronous reset mid-SEND
      edge_();
      tx_ready    = 1'b0;
      req_data[2] = 8'h5A; req_last[2] = 1'b0;
      req_data[0] = 8'h41; req_last[0] = 1'b1;
      req_valid   = 4'b0101;
      mid();  chk("t6_grant2", 32'(req_ready), 32'b0100);
      edge_(); req_valid[2] = 1'b0;
      mid();  chk("t6_avail", 32'(tx_data_available), 32'd1);
              chk("t6_data", 32'(tx_data), 32'h5A);
      #1 reset_n = 1'b0; tx_ready = 1'b1;
      #1;     chk("t6_rst_avail", 32'(tx_data_available), 32'd0);
              chk("t6_rst_busy", 32'(busy), 32'd0);
              chk("t6_rst_data", 32'(tx_data), 32'h00);
      #1 reset_n = 1'b1;
      #1;     chk("t6_grant0", 32'(req_ready), 32'b0001);
      edge_(); req_valid = '0;
      mid();  chk("t6_data0", 32'(tx_data), 32'h41);
              chk("t6_owner0", 32'(owner), 32'd0);
      edge_(); mid();
              chk("t6_end_busy", 32'(busy), 32'd0);
              chk("t6_end_avail", 32'(tx_data_available), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_serial_tx_arbiter
`default_nettype wire
